// File: rtl/regfile_sb.sv
// Scoreboarded register file: combinational multi-port reads with per-register pending bits,
// a post-reset INIT sweep that clears the array, and optional write-to-read forwarding (REGFILE_SB_BYPASS_EN).
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] R_reg,
  output logic [NUM_RD*DATA_W-1:0] R_data,
  output logic [NUM_RD-1:0]        R_rdy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        W_reg,
  input  logic [DATA_W-1:0]        W_data,
  output logic                     init_busy,
  output logic                     dbg_state
);

  // Handshake: issue_valid and regWrite are single-cycle strobes sampled on the rising
  // edge while in RUN; there is no back-pressure, and both are dropped during INIT.

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pending_q;
  logic                run;
  logic                wr_ok;
  logic                iss_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign run       = (state_q == S_RUN);
  assign init_busy = !run;
  assign dbg_state = state_q;
  assign wr_ok     = run && regWrite && in_range(W_reg) && !is_zero(W_reg);
  assign iss_ok    = run && issue_valid && in_range(issue_reg) && !is_zero(issue_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (cnt_q == LAST_IDX) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // The array has no reset; the INIT sweep is the only thing that clears it.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[W_reg] <= W_data;
    end
  end

  // Set after clear so a same-cycle issue keeps the register pending for the newer producer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else if (run) begin
      if (wr_ok)  pending_q[W_reg]     <= 1'b0;
      if (iss_ok) pending_q[issue_reg] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              valid_a;
    logic [DATA_W-1:0] rd_data;
    logic              rd_rdy;

    assign ra      = R_reg[k*ADDR_W +: ADDR_W];
    assign valid_a = in_range(ra) && !is_zero(ra);

    always_comb begin
      rd_data = valid_a ? mem[ra] : '0;
      rd_rdy  = run && (!valid_a || !pending_q[ra]);
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_ok && (W_reg == ra)) begin
        rd_data = W_data;
        rd_rdy  = !(iss_ok && (issue_reg == W_reg));
      end
`endif
    end

    assign R_data[k*DATA_W +: DATA_W] = rd_data;
    assign R_rdy[k]                   = rd_rdy;
  end

endmodule
